// File: rtl/cnn_acc_ci_sched_pkg.sv
// Shared types and sizing helpers for the cnn_acc_ci output-map sequencer.
// Optional performance counters are enabled with CNN_ACC_CI_SCHED_PERF_EN.
package cnn_acc_ci_sched_pkg;

  localparam logic [1:0] S_IDLE_ENC  = 2'd0;
  localparam logic [1:0] S_RUN_ENC   = 2'd1;
  localparam logic [1:0] S_DRAIN_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE_ENC,
    ST_RUN   = S_RUN_ENC,
    ST_DRAIN = S_DRAIN_ENC
  } sched_state_e;

  localparam int unsigned DEF_OX      = 4;
  localparam int unsigned DEF_OY      = 4;
  localparam int unsigned DEF_CO      = 2;
  localparam int unsigned DEF_CREDITS = 4;
  localparam int unsigned DEF_TOTAL   = DEF_OX * DEF_OY * DEF_CO;

  // Index width: enough to address 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter width: enough to hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_TOTAL_W  = cnt_w(DEF_TOTAL);
  localparam int unsigned DEF_CREDIT_W = cnt_w(DEF_CREDITS);

endpackage

// File: rtl/cnn_acc_ci_sched_idx_cnt.sv
// Three-level wrapping point counter: ox fastest, then oy, then co.
// last_o flags the final point of the map at the current count.
module cnn_sched_idx_cnt
  import cnn_acc_ci_sched_pkg::*;
#(
  parameter int unsigned OX = DEF_OX,
  parameter int unsigned OY = DEF_OY,
  parameter int unsigned CO = DEF_CO
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [idx_w(OX)-1:0] ox_o,
  output logic [idx_w(OY)-1:0] oy_o,
  output logic [idx_w(CO)-1:0] co_o,
  output logic                 last_o
);

  localparam int unsigned XW = idx_w(OX);
  localparam int unsigned YW = idx_w(OY);
  localparam int unsigned CW = idx_w(CO);

  logic [XW-1:0] ox_q;
  logic [YW-1:0] oy_q;
  logic [CW-1:0] co_q;
  logic          last_x, last_y, last_c;

  assign last_x = (ox_q == XW'(OX - 1));
  assign last_y = (oy_q == YW'(OY - 1));
  assign last_c = (co_q == CW'(CO - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ox_q <= '0;
      oy_q <= '0;
      co_q <= '0;
    end else if (clr_i) begin
      ox_q <= '0;
      oy_q <= '0;
      co_q <= '0;
    end else if (en_i) begin
      if (last_x) begin
        ox_q <= '0;
        if (last_y) begin
          oy_q <= '0;
          co_q <= last_c ? '0 : co_q + CW'(1);
        end else begin
          oy_q <= oy_q + YW'(1);
        end
      end else begin
        ox_q <= ox_q + XW'(1);
      end
    end
  end

  assign ox_o   = ox_q;
  assign oy_o   = oy_q;
  assign co_o   = co_q;
  assign last_o = last_x & last_y & last_c;

endmodule

// File: rtl/cnn_acc_ci_sched.sv
// Output-map sequencer for one cnn_acc_ci datapath: credit-throttled issue,
// result counting and completion. CNN_ACC_CI_SCHED_PERF_EN adds cycle counters.
//
// Handshake: a point is committed on the edge where go is high (credit taken,
// counter advanced); o_in_valid is high the following cycle with its indices.
// i_ot_valid and i_credit_ret are single-cycle strobes, one event per cycle.
module cnn_acc_ci_sched
  import cnn_acc_ci_sched_pkg::*;
#(
  parameter int unsigned OX       = DEF_OX,
  parameter int unsigned OY       = DEF_OY,
  parameter int unsigned CO       = DEF_CO,
  parameter int unsigned CREDITS  = DEF_CREDITS,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_soft_reset,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_in_valid,
  output logic [idx_w(OX)-1:0] o_ox,
  output logic [idx_w(OY)-1:0] o_oy,
  output logic [idx_w(CO)-1:0] o_co,
  input  logic                 i_ot_valid,
  input  logic                 i_credit_ret,
  output logic                 o_err
`ifdef CNN_ACC_CI_SCHED_PERF_EN
  ,
  output logic [31:0]          o_run_cycles,
  output logic [31:0]          o_stall_cycles
`endif
);

  localparam int unsigned TOTAL = OX * OY * CO;
  localparam int unsigned TW    = cnt_w(TOTAL);
  localparam int unsigned CRW   = cnt_w(CREDITS);
  localparam int unsigned XW    = idx_w(OX);
  localparam int unsigned YW    = idx_w(OY);
  localparam int unsigned CW    = idx_w(CO);

  if (OX < 1 || OY < 1 || CO < 1 || CREDITS < 1 || PIPE_LAT < 1) begin : g_bad_param
    $error("cnn_acc_ci_sched: OX, OY, CO, CREDITS and PIPE_LAT must all be >= 1");
  end

  sched_state_e   state_q, state_d;
  logic [CRW-1:0] credits_q, credits_d;
  logic [TW-1:0]  issued_q, returned_q;
  logic           all_issued_q;
  logic           in_valid_q, err_q;
  logic [XW-1:0]  ox_q, cnt_ox;
  logic [YW-1:0]  oy_q, cnt_oy;
  logic [CW-1:0]  co_q, cnt_co;
  logic           cnt_last;

  logic busy_st, ot_ok, done, go, ret_over, err_set;

  cnn_sched_idx_cnt #(
    .OX (OX),
    .OY (OY),
    .CO (CO)
  ) u_idx (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (i_soft_reset),
    .en_i    (go),
    .ox_o    (cnt_ox),
    .oy_o    (cnt_oy),
    .co_o    (cnt_co),
    .last_o  (cnt_last)
  );

  always_comb begin
    busy_st  = (state_q != ST_IDLE);
    ot_ok    = i_ot_valid && busy_st && (issued_q != returned_q);
    done     = !i_soft_reset && ot_ok && (returned_q == TW'(TOTAL - 1));
    go       = !i_soft_reset && (credits_q != '0) &&
               ((state_q == ST_IDLE && i_start) || (state_q == ST_RUN && !all_issued_q));
    // A return is only excess when no issue consumes a slot in the same cycle.
    ret_over = i_credit_ret && !go && (credits_q == CRW'(CREDITS));
    err_set  = ret_over || (i_ot_valid && !ot_ok);

    credits_d = credits_q;
    if (go && !i_credit_ret) begin
      credits_d = credits_q - CRW'(1);
    end else if (!go && i_credit_ret && !ret_over) begin
      credits_d = credits_q + CRW'(1);
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_RUN;
      ST_RUN:   if (done) state_d = ST_IDLE;
                else if (all_issued_q) state_d = ST_DRAIN;
      ST_DRAIN: if (done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      credits_q    <= CRW'(CREDITS);
      issued_q     <= '0;
      returned_q   <= '0;
      all_issued_q <= 1'b0;
      in_valid_q   <= 1'b0;
      ox_q         <= '0;
      oy_q         <= '0;
      co_q         <= '0;
      err_q        <= 1'b0;
    end else if (i_soft_reset) begin
      state_q      <= ST_IDLE;
      credits_q    <= CRW'(CREDITS);
      issued_q     <= '0;
      returned_q   <= '0;
      all_issued_q <= 1'b0;
      in_valid_q   <= 1'b0;
      ox_q         <= '0;
      oy_q         <= '0;
      co_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      in_valid_q <= go;
      if (err_set) err_q <= 1'b1;

      if (done) begin
        issued_q     <= '0;
        returned_q   <= '0;
        all_issued_q <= 1'b0;
      end else begin
        if (go) issued_q <= issued_q + TW'(1);
        if (ot_ok) returned_q <= returned_q + TW'(1);
        if (go && cnt_last) all_issued_q <= 1'b1;
      end

      // Indices follow the committed point; they hold across a credit stall
      // and return to zero once the map has been fully issued.
      if (go) begin
        ox_q <= cnt_ox;
        oy_q <= cnt_oy;
        co_q <= cnt_co;
      end else if (state_d != ST_RUN) begin
        ox_q <= '0;
        oy_q <= '0;
        co_q <= '0;
      end
    end
  end

  assign o_busy     = busy_st && !done;
  assign o_done     = done;
  assign o_in_valid = in_valid_q;
  assign o_ox       = ox_q;
  assign o_oy       = oy_q;
  assign o_co       = co_q;
  assign o_err      = err_q;

`ifdef CNN_ACC_CI_SCHED_PERF_EN
  logic [31:0] run_cycles_q, stall_cycles_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cycles_q   <= '0;
      stall_cycles_q <= '0;
    end else if (i_soft_reset || (state_q == ST_IDLE && i_start)) begin
      run_cycles_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (busy_st && run_cycles_q != '1) run_cycles_q <= run_cycles_q + 32'd1;
      if (state_q == ST_RUN && credits_q == '0 && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign o_run_cycles   = run_cycles_q;
  assign o_stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cnn_acc_ci_sched.sv
// Directed bench for cnn_acc_ci_sched (OX=OY=CO=2, CREDITS=2, PIPE_LAT=3)
// with a scoreboard of expected issue indices and a small datapath latency model.
module tb_cnn_acc_ci_sched;

  localparam int unsigned OX       = 2;
  localparam int unsigned OY       = 2;
  localparam int unsigned CO       = 2;
  localparam int unsigned CREDITS  = 2;
  localparam int unsigned PIPE_LAT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_soft_reset = 1'b0;
  logic       i_start = 1'b0;
  logic       o_busy, o_done, o_in_valid, o_err;
  logic [0:0] o_ox, o_oy, o_co;
  logic       i_ot_valid, i_credit_ret;
`ifdef CNN_ACC_CI_SCHED_PERF_EN
  logic [31:0] o_run_cycles, o_stall_cycles;
`endif

  logic auto_ret = 1'b0;
  logic dly_ret  = 1'b0;
  logic man_ret  = 1'b0;
  logic man_ot   = 1'b0;

  logic [PIPE_LAT-1:0] pipe_q;
  logic [1:0]          rdly_q;

  logic [2:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int iv_count = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  cnn_acc_ci_sched #(
    .OX       (OX),
    .OY       (OY),
    .CO       (CO),
    .CREDITS  (CREDITS),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_soft_reset   (i_soft_reset),
    .i_start        (i_start),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_in_valid     (o_in_valid),
    .o_ox           (o_ox),
    .o_oy           (o_oy),
    .o_co           (o_co),
    .i_ot_valid     (i_ot_valid),
    .i_credit_ret   (i_credit_ret),
    .o_err          (o_err)
`ifdef CNN_ACC_CI_SCHED_PERF_EN
    ,
    .o_run_cycles   (o_run_cycles),
    .o_stall_cycles (o_stall_cycles)
`endif
  );

  // Datapath model: result PIPE_LAT cycles after issue; optional credit return
  // two cycles after issue. Cleared together with the scheduler's soft reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
      rdly_q <= '0;
    end else if (i_soft_reset) begin
      pipe_q <= '0;
      rdly_q <= '0;
    end else begin
      pipe_q <= {pipe_q[PIPE_LAT-2:0], o_in_valid};
      rdly_q <= {rdly_q[0], o_in_valid};
    end
  end

  assign i_ot_valid   = pipe_q[PIPE_LAT-1] | man_ot;
  assign i_credit_ret = (auto_ret & o_in_valid) | (dly_ret & rdly_q[1]) | man_ret;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every issue strobe is checked against the next expected point.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (o_in_valid) begin
        iv_count++;
        if (exp_q.size() == 0) begin
          check("issue_unexpected", {29'd0, o_co, o_oy, o_ox}, 32'hFFFF_FFFF);
        end else begin
          check("issue_idx", {29'd0, o_co, o_oy, o_ox}, {29'd0, exp_q.pop_front()});
        end
      end
      if (o_done) begin
        done_count++;
        check("busy_low_at_done", {31'd0, o_busy}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_points(input int n);
    int k = 0;
    for (int co = 0; co < int'(CO); co++)
      for (int oy = 0; oy < int'(OY); oy++)
        for (int ox = 0; ox < int'(OX); ox++) begin
          if (k < n) exp_q.push_back(3'((co << 2) | (oy << 1) | ox));
          k++;
        end
  endtask

  task automatic pulse_start(output int sc);
    i_start = 1'b1;
    sc = cyc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic soft_reset();
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int sc, at, i0, d0, c0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_in_valid", {31'd0, o_in_valid}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_idx", {29'd0, o_co, o_oy, o_ox}, 32'd0);

    // Full map with a credit returned alongside every issue.
    tick();
    auto_ret = 1'b1;
    push_points(8);
    i0 = iv_count;
    d0 = done_count;
    pulse_start(sc);
    @(negedge clk);
    check("t1_busy_running", {31'd0, o_busy}, 32'd1);
    wait_done(40, at);
    check("t1_done_cycle", at, sc + 1 + 7 + PIPE_LAT);
    tick();
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, o_done}, 32'd0);
    check("t1_idle_busy", {31'd0, o_busy}, 32'd0);
    check("t1_err", {31'd0, o_err}, 32'd0);
    check("t1_issue_count", iv_count - i0, 32'd8);
    check("t1_done_count", done_count - d0, 32'd1);
    check("t1_sb_empty", exp_q.size(), 32'd0);

    // No credit returns: issue stops when the two credits are spent.
    tick();
    auto_ret = 1'b0;
    push_points(3);
    i0 = iv_count;
    pulse_start(sc);
    repeat (8) tick();
    @(negedge clk);
    check("t2_stall_issues", iv_count - i0, 32'd2);
    check("t2_stall_busy", {31'd0, o_busy}, 32'd1);
    check("t2_stall_in_valid", {31'd0, o_in_valid}, 32'd0);
    tick();
    man_ret = 1'b1;
    c0 = cyc;
    tick();
    man_ret = 1'b0;
    tick();
    @(negedge clk);
    check("t2_refill_cycle", cyc - c0, 32'd2);
    check("t2_refill_issue", {31'd0, o_in_valid}, 32'd1);
    repeat (6) tick();
    check("t2_refill_count", iv_count - i0, 32'd3);
    check("t2_err", {31'd0, o_err}, 32'd0);

    // Abort mid-job, then a fresh job from point zero.
    d0 = done_count;
    soft_reset();
    @(negedge clk);
    check("t4_abort_busy", {31'd0, o_busy}, 32'd0);
    check("t4_abort_in_valid", {31'd0, o_in_valid}, 32'd0);
    check("t4_abort_idx", {29'd0, o_co, o_oy, o_ox}, 32'd0);
    repeat (4) tick();
    check("t4_no_done", done_count - d0, 32'd0);
    check("t4_sb_empty", exp_q.size(), 32'd0);
    auto_ret = 1'b1;
    push_points(8);
    i0 = iv_count;
    pulse_start(sc);
    wait_done(40, at);
    check("t4_done_cycle", at, sc + 1 + 7 + PIPE_LAT);
    tick();
    auto_ret = 1'b0;
    check("t4_issue_count", iv_count - i0, 32'd8);
    check("t4_sb_empty_end", exp_q.size(), 32'd0);
    check("t4_err", {31'd0, o_err}, 32'd0);

    // Protocol errors: stray result in IDLE, excess credit at full.
    man_ot = 1'b1;
    tick();
    man_ot = 1'b0;
    @(negedge clk);
    check("t5_err_idle_ot", {31'd0, o_err}, 32'd1);
    repeat (5) tick();
    check("t5_err_sticky", {31'd0, o_err}, 32'd1);
    soft_reset();
    @(negedge clk);
    check("t5_err_cleared", {31'd0, o_err}, 32'd0);
    tick();
    man_ret = 1'b1;
    tick();
    man_ret = 1'b0;
    @(negedge clk);
    check("t5_err_credit_over", {31'd0, o_err}, 32'd1);
    soft_reset();
    @(negedge clk);
    check("t5_err_cleared2", {31'd0, o_err}, 32'd0);

`ifdef CNN_ACC_CI_SCHED_PERF_EN
    // Credits return two cycles after issue: issues pair up with two-cycle gaps.
    tick();
    dly_ret = 1'b1;
    push_points(8);
    pulse_start(sc);
    wait_done(60, at);
    check("t6_done_cycle", at, sc + 17);
    tick();
    @(negedge clk);
    check("t6_stall_cycles", o_stall_cycles, 32'd7);
    check("t6_run_cycles", o_run_cycles, 32'd17);
    repeat (3) tick();
    check("t6_run_hold", o_run_cycles, 32'd17);
    check("t6_sb_empty", exp_q.size(), 32'd0);
    dly_ret = 1'b0;
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
